// File: rtl/condicionador_botoes_pkg.sv
// Shared game constants: FSM state encodings, debounce default and one-hot helpers
// used by the button conditioner and the game controller.
package condicionador_botoes_pkg;

    localparam int N_DEB_PADRAO   = 3;
    localparam int LARGURA_BOTOES = 4;

    typedef enum logic [2:0] {
        OCIOSO         = 3'd0,
        FILTRANDO      = 3'd1,
        EMITE          = 3'd2,
        AGUARDA_SOLTAR = 3'd3
    } estado_t;

    function automatic logic eh_one_hot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    function automatic logic [1:0] indice_one_hot(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/condicionador_botoes_if.sv
// Button-conditioner bus: raw buttons and move-enable in, move pulses/code/debug out.
interface condicionador_botoes_if;
    import condicionador_botoes_pkg::*;

    logic [LARGURA_BOTOES-1:0] botoes;
    logic                      habilita;
    logic                      jogada;
    logic                      invalida;
    logic [LARGURA_BOTOES-1:0] botao_codigo;
    logic [1:0]                botao_indice;
    logic [2:0]                db_estado;

    modport master (
        output botoes, habilita,
        input  jogada, invalida, botao_codigo, botao_indice, db_estado
    );

    modport slave (
        input  botoes, habilita,
        output jogada, invalida, botao_codigo, botao_indice, db_estado
    );

endinterface

// File: rtl/condicionador_botoes_sincronizador_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
module sincronizador_2ff #(
    parameter int LARGURA = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [LARGURA-1:0] d,
    output logic [LARGURA-1:0] q
);

    logic [LARGURA-1:0] meta_r;
    logic [LARGURA-1:0] sinc_r;

    // metastability stage followed by the stable output stage
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_r <= '0;
            sinc_r <= '0;
        end else begin
            meta_r <= d;
            sinc_r <= meta_r;
        end
    end

    assign q = sinc_r;

endmodule

// File: rtl/condicionador_botoes.sv
// Debounces the four colour buttons and emits one move pulse per stable press,
// flagging presses that are not one-hot as invalid.
module condicionador_botoes
    import condicionador_botoes_pkg::*;
#(
    parameter int N_DEB = N_DEB_PADRAO
) (
    input  logic                  clock,
    input  logic                  reset,
    condicionador_botoes_if.slave bus
);

    localparam logic [7:0] LIMITE = 8'(N_DEB - 1);

    logic [3:0] sinc_s;
    estado_t    estado_r;
    estado_t    prox_s;
    logic [3:0] amostra_r;
    logic [3:0] amostra_prox_s;
    logic [7:0] cont_r;
    logic [7:0] cont_prox_s;
    logic       emite_s;
    logic       valido_s;
    logic       jogada_r;
    logic       invalida_r;
    logic [3:0] codigo_r;
    logic [1:0] indice_r;

    sincronizador_2ff #(.LARGURA(LARGURA_BOTOES)) u_sinc (
        .clock (clock),
        .reset (reset),
        .d     (bus.botoes),
        .q     (sinc_s)
    );

    // state, sample and counter registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_r  <= OCIOSO;
            amostra_r <= 4'b0000;
            cont_r    <= 8'd0;
        end else begin
            estado_r  <= prox_s;
            amostra_r <= amostra_prox_s;
            cont_r    <= cont_prox_s;
        end
    end

    // next-state, sample and counter logic; loss of enable while filtering wins over everything
    always_comb begin
        prox_s         = OCIOSO;
        amostra_prox_s = amostra_r;
        cont_prox_s    = cont_r;
        case (estado_r)
            OCIOSO: begin
                if ((sinc_s != 4'b0000) && (bus.habilita == 1'b1)) begin
                    prox_s         = FILTRANDO;
                    amostra_prox_s = sinc_s;
                    cont_prox_s    = 8'd1;
                end else begin
                    prox_s = OCIOSO;
                end
            end
            FILTRANDO: begin
                if (bus.habilita == 1'b0) begin
                    prox_s      = AGUARDA_SOLTAR;
                    cont_prox_s = 8'd0;
                end else if (sinc_s == 4'b0000) begin
                    prox_s = OCIOSO;
                end else if (sinc_s != amostra_r) begin
                    prox_s         = FILTRANDO;
                    amostra_prox_s = sinc_s;
                    cont_prox_s    = 8'd1;
                end else if (cont_r == LIMITE) begin
                    prox_s = EMITE;
                end else begin
                    prox_s      = FILTRANDO;
                    cont_prox_s = cont_r + 8'd1;
                end
            end
            EMITE: begin
                prox_s      = AGUARDA_SOLTAR;
                cont_prox_s = 8'd0;
            end
            AGUARDA_SOLTAR: begin
                if (sinc_s != 4'b0000) begin
                    prox_s      = AGUARDA_SOLTAR;
                    cont_prox_s = 8'd0;
                end else if (cont_r == LIMITE) begin
                    prox_s      = OCIOSO;
                    cont_prox_s = 8'd0;
                end else begin
                    prox_s      = AGUARDA_SOLTAR;
                    cont_prox_s = cont_r + 8'd1;
                end
            end
            default: begin
                prox_s      = OCIOSO;
                cont_prox_s = 8'd0;
            end
        endcase
    end

    assign emite_s  = (prox_s == EMITE);
    assign valido_s = eh_one_hot(amostra_prox_s);

    // Moore outputs registered on entry to EMITE so pulse and code appear together
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            jogada_r   <= 1'b0;
            invalida_r <= 1'b0;
            codigo_r   <= 4'b0000;
            indice_r   <= 2'd0;
        end else begin
            jogada_r   <= emite_s && valido_s;
            invalida_r <= emite_s && !valido_s;
            if (emite_s && valido_s) begin
                codigo_r <= amostra_prox_s;
                indice_r <= indice_one_hot(amostra_prox_s);
            end else begin
                codigo_r <= codigo_r;
                indice_r <= indice_r;
            end
        end
    end

    assign bus.jogada       = jogada_r;
    assign bus.invalida     = invalida_r;
    assign bus.botao_codigo = codigo_r;
    assign bus.botao_indice = indice_r;
    assign bus.db_estado    = estado_r;

endmodule
